// File: rtl/acquisition_sequencer.sv
// Acquisition sequencer: waits for a trigger edge, fills the waveform buffer
// with NUM_SAMPLES ADC samples, then releases the serializer (acquire=0) for
// one full transmission and holds off before re-arming.
// Ports:
//   clk, rst_n            - single clock, asynchronous active-low reset
//   enable, single_shot   - arm control; single_shot returns to IDLE after one waveform
//   trigger, sample_valid - trigger level (rising edge starts capture), ADC sample strobe
//   acquire               - 1 holds the serializer in reset, 0 lets it transmit
//   wr_en, wr_addr        - registered waveform-buffer write strobe and index
//   wave_number           - waveform counter handed to the serializer frame
//   busy, state           - status: busy in CAPTURE/SEND/HOLDOFF, encoded FSM state
//   missed_trig           - saturating count of trigger edges ignored while busy
module acquisition_sequencer #(
  parameter int NUM_SAMPLES     = 500,
  parameter int BITS_PER_SAMPLE = 36,
  parameter int HOLDOFF_CYCLES  = 1000,
  parameter int ADDR_W          = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              single_shot,
  input  logic              trigger,
  input  logic              sample_valid,
  output logic              acquire,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wave_number,
  output logic              busy,
  output logic [2:0]        state,
  output logic [7:0]        missed_trig
);

  // The serializer sends every sample plus the wave-number frame.
  localparam int SEND_CYCLES = (NUM_SAMPLES + 1) * BITS_PER_SAMPLE;
  localparam int CNT_W       = ADDR_W + 1;
  localparam int SEND_W      = $clog2(SEND_CYCLES + 1);
  localparam int HOLD_W      = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [SEND_W-1:0] SEND_LAST   = SEND_W'(SEND_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               trigger_d;
  logic               trig_edge;
  logic [CNT_W-1:0]   sample_cnt;
  logic [SEND_W-1:0]  send_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [15:0]        wave_q;
  logic               capture_start;
  logic               write_now;
  logic               send_done;

  assign trig_edge   = trigger & ~trigger_d;
  assign acquire     = (state_q != S_SEND);
  assign busy        = (state_q == S_CAPTURE) || (state_q == S_SEND) ||
                       (state_q == S_HOLDOFF);
  assign state       = state_q;
  assign wave_number = wave_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    capture_start = 1'b0;
    write_now     = 1'b0;
    send_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_ARM;
      end
      S_ARM: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (trig_edge) begin
          state_d       = S_CAPTURE;
          capture_start = 1'b1;
        end
      end
      S_CAPTURE: begin
        // Dropping enable abandons the partial buffer; a strobe in the same
        // cycle is discarded along with it.
        if (!enable) begin
          state_d = S_IDLE;
        end else if (sample_valid) begin
          write_now = 1'b1;
          if (sample_cnt == SAMPLE_LAST) state_d = S_SEND;
        end
      end
      S_SEND: begin
        // Transmission always runs to completion regardless of enable.
        if (send_cnt == SEND_LAST) begin
          state_d   = S_HOLDOFF;
          send_done = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (hold_cnt == HOLD_LAST) begin
          state_d = (enable && !single_shot) ? S_ARM : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trigger_d   <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      sample_cnt  <= '0;
      send_cnt    <= '0;
      hold_cnt    <= '0;
      wave_q      <= 16'd0;
      missed_trig <= 8'd0;
    end else begin
      trigger_d <= trigger;
      wr_en     <= write_now;
      if (write_now) wr_addr <= sample_cnt[ADDR_W-1:0];

      if (capture_start) begin
        sample_cnt <= '0;
      end else if (write_now) begin
        sample_cnt <= sample_cnt + 1'b1;
      end

      // Both interval counters sit at zero outside their own state, so each
      // state entry starts counting from zero.
      send_cnt <= (state_q == S_SEND)    ? send_cnt + 1'b1 : '0;
      hold_cnt <= (state_q == S_HOLDOFF) ? hold_cnt + 1'b1 : '0;

      // Natural 16-bit wrap from 0xFFFF to 0.
      if (send_done) wave_q <= wave_q + 16'd1;

      if (busy && trig_edge && (missed_trig != 8'hFF)) begin
        missed_trig <= missed_trig + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_acquisition_sequencer.sv
module tb_acquisition_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        single_shot;
  logic        trigger;
  logic        sample_valid;
  logic        acquire;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wave_number;
  logic        busy;
  logic [2:0]  state;
  logic [7:0]  missed_trig;

  int compared;
  int mismatched;
  int n;

  acquisition_sequencer #(
    .NUM_SAMPLES    (4),
    .BITS_PER_SAMPLE(36),
    .HOLDOFF_CYCLES (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .single_shot (single_shot),
    .trigger     (trigger),
    .sample_valid(sample_valid),
    .acquire     (acquire),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wave_number (wave_number),
    .busy        (busy),
    .state       (state),
    .missed_trig (missed_trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Trigger from ARM, then four back-to-back samples; returns on the first SEND cycle.
  task automatic capture_burst();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    sample_valid = 1'b1;
    repeat (4) tick();
    sample_valid = 1'b0;
  endtask

  // Count cycles with acquire low, bounded so a stuck DUT cannot hang the run.
  task automatic measure_send(output int cycles);
    cycles = 0;
    while (acquire === 1'b0 && cycles < 1000) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    single_shot  = 1'b0;
    trigger      = 1'b0;
    sample_valid = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_state",   32'(state), 32'd0);
    check("rst_acquire", 32'(acquire), 32'd1);
    check("rst_wr_en",   32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wave",    32'(wave_number), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_missed",  32'(missed_trig), 32'd0);

    rst_n = 1'b1;
    tick();
    check("idle_hold", 32'(state), 32'd0);
    enable = 1'b1;
    tick();
    check("arm", 32'(state), 32'd1);

    // Strobe outside CAPTURE must not write
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("arm_no_write", 32'(wr_en), 32'd0);

    // Basic capture: samples every other cycle
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("cap_state",   32'(state), 32'd2);
    check("cap_busy",    32'(busy), 32'd1);
    check("cap_acquire", 32'(acquire), 32'd1);
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      check("wr_pulse", 32'(wr_en), 32'd1);
      check("wr_index", 32'(wr_addr), 32'(i));
      if (i < 3) begin
        tick();
        check("wr_gap", 32'(wr_en), 32'd0);
      end
    end
    check("send_state",   32'(state), 32'd3);
    check("send_acquire", 32'(acquire), 32'd0);
    check("send_wave",    32'(wave_number), 32'd0);
    measure_send(n);
    check("send_len",      32'(n), 32'd180);
    check("wave_after1",   32'(wave_number), 32'd1);
    check("holdoff_entry", 32'(state), 32'd4);
    tick();
    tick();
    check("holdoff_last", 32'(state), 32'd4);
    tick();
    check("rearm",         32'(state), 32'd1);
    check("rearm_acquire", 32'(acquire), 32'd1);
    check("rearm_busy",    32'(busy), 32'd0);

    // Trigger edges at SEND cycles 10, 50, 100 are counted and ignored
    capture_burst();
    check("mt_send", 32'(state), 32'd3);
    n = 0;
    while (acquire === 1'b0 && n < 1000) begin
      trigger = (n == 10 || n == 50 || n == 100);
      n++;
      tick();
    end
    trigger = 1'b0;
    check("mt_send_len", 32'(n), 32'd180);
    check("mt_count",    32'(missed_trig), 32'd3);
    check("mt_state",    32'(state), 32'd4);
    check("mt_wave",     32'(wave_number), 32'd2);
    repeat (3) tick();
    check("mt_rearm", 32'(state), 32'd1);

    // Single shot: back to IDLE after one waveform
    single_shot = 1'b1;
    capture_burst();
    measure_send(n);
    check("ss_send_len", 32'(n), 32'd180);
    check("ss_wave",     32'(wave_number), 32'd3);
    tick();
    tick();
    check("ss_holdoff", 32'(state), 32'd4);
    tick();
    check("ss_idle", 32'(state), 32'd0);
    enable = 1'b0;
    tick();
    repeat (2) begin
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
    end
    check("ss_final_state", 32'(state), 32'd0);
    check("ss_final_wave",  32'(wave_number), 32'd3);
    check("ss_idle_missed", 32'(missed_trig), 32'd3);
    single_shot = 1'b0;

    // Abort during capture after two samples
    enable = 1'b1;
    tick();
    check("ab_arm", 32'(state), 32'd1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    sample_valid = 1'b1;
    tick();
    tick();
    sample_valid = 1'b0;
    check("ab_two_writes", 32'(wr_addr), 32'd1);
    enable = 1'b0;
    tick();
    check("ab_state",   32'(state), 32'd0);
    check("ab_acquire", 32'(acquire), 32'd1);
    check("ab_wave",    32'(wave_number), 32'd3);

    // 300 edges while busy: saturates rather than wrapping
    enable = 1'b1;
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("sat_capture", 32'(state), 32'd2);
    repeat (300) begin
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
    end
    check("sat_missed", 32'(missed_trig), 32'd255);
    check("sat_state",  32'(state), 32'd2);
    enable = 1'b0;
    tick();
    check("sat_idle", 32'(state), 32'd0);

    // Reset at cycle 90 of SEND
    enable = 1'b1;
    tick();
    capture_burst();
    check("rs_send", 32'(state), 32'd3);
    repeat (90) tick();
    check("rs_mid_send", 32'(acquire), 32'd0);
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("rs_state",   32'(state), 32'd0);
    check("rs_acquire", 32'(acquire), 32'd1);
    check("rs_busy",    32'(busy), 32'd0);
    check("rs_missed",  32'(missed_trig), 32'd0);
    check("rs_wave",    32'(wave_number), 32'd0);
    check("rs_wr_en",   32'(wr_en), 32'd0);
    check("rs_wr_addr", 32'(wr_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    check("rs_rearm", 32'(state), 32'd1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    sample_valid = 1'b1;
    tick();
    check("rs_first_wr_en",  32'(wr_en), 32'd1);
    check("rs_first_wr_idx", 32'(wr_addr), 32'd0);
    tick();
    check("rs_second_wr_idx", 32'(wr_addr), 32'd1);
    sample_valid = 1'b0;

    // Wave-number wrap: preload the counter to 0xFFFF mid-capture
    force dut.wave_q = 16'hFFFF;
    #1;
    release dut.wave_q;
    tick();
    check("wrap_preload", 32'(wave_number), 32'h0000FFFF);
    sample_valid = 1'b1;
    tick();
    tick();
    sample_valid = 1'b0;
    check("wrap_send",      32'(state), 32'd3);
    check("wrap_send_wave", 32'(wave_number), 32'h0000FFFF);
    measure_send(n);
    check("wrap_send_len", 32'(n), 32'd180);
    check("wrap_wave",     32'(wave_number), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
